// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: register-index width, the
// issue-class and branch-FSM encodings, default unit latencies and the
// writeback reservation entry format.
package issue_scoreboard_pkg;

    localparam int REG_W        = 5;
    localparam int NUM_REGS     = 32;

    localparam int ALU_LAT_DEF  = 1;
    localparam int MEM_LAT_DEF  = 3;
    localparam int LONG_LAT_DEF = 6;
    localparam int MAX_LAT_DEF  = 6;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_MEM  = 2'd2,
        CLS_LONG = 2'd3
    } iss_class_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    // One writeback reservation: a valid flag and the register to write.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } wb_entry_t;

endpackage

// File: rtl/issue_scoreboard_wb_sched.sv
// Writeback reservation queue.
// slot_q[k] holds the writeback that happens k cycles from now; slot_q[0] is
// the register-file write of the current cycle (wb_valid/wb_reg) and also
// serves as the pending-clear strobe for the scoreboard.
// Ports:
//   clk, rst_n           clock, async active-low reset (drops all entries)
//   ins_valid            reserve a writeback this cycle
//   ins_lat              issue-to-writeback latency of the reservation (1..MAX_LAT)
//   ins_reg              register to be written
//   slot_busy[k]         a writeback is already booked k cycles from now
//   wb_valid, wb_reg     register-file write of this cycle
module issue_scoreboard_wb_sched
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ins_valid,
    input  logic [LAT_W-1:0]   ins_lat,
    input  logic [REG_W-1:0]   ins_reg,
    output logic [MAX_LAT:1]   slot_busy,
    output logic               wb_valid,
    output logic [REG_W-1:0]   wb_reg
);

    wb_entry_t slot_q [MAX_LAT];
    wb_entry_t slot_d [MAX_LAT];

    // Shift every reservation one cycle closer, then book the new one. A
    // writeback due lat cycles after the issue edge lands in slot lat-1 right
    // after that edge. The caller guarantees the target slot is free.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            slot_d[k] = slot_q[k + 1];
        end
        slot_d[MAX_LAT - 1] = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (ins_valid && ins_lat == LAT_W'(k + 1)) begin
                slot_d[k] = '{valid: 1'b1, rd: ins_reg};
            end
        end
    end

    // Nothing can be booked MAX_LAT cycles ahead of the current cycle, so the
    // top bit stays clear.
    always_comb begin
        slot_busy = '0;
        for (int k = 1; k < MAX_LAT; k++) begin
            slot_busy[k] = slot_q[k].valid;
        end
    end

    assign wb_valid = slot_q[0].valid;
    assign wb_reg   = slot_q[0].rd;

    // NOTE: the queue is reset element by element because in-flight writebacks must be dropped on reset.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller between decode and the ALU / memory / long-op units.
// Tracks pending register writes, stalls decode on RAW/WAW hazards, writeback
// port conflicts, a busy long unit and unresolved branches, schedules the
// register-file writeback and pulses flush on a taken branch.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   dec_valid / dec_ready         decode handshake; issue when both are high
//   rs, rt, rd                    register indices from decode
//   alu_src, alu_reg_write,
//   mem_reg_write, long_write,
//   mem_write, branch             decode control fields
//   iss_valid, iss_class, iss_dest  issue strobe, unit class, destination
//   br_resolved, br_taken         branch outcome pulse
//   flush                         one-cycle discard of younger instructions
//   wb_valid, wb_reg              register-file write of this cycle
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int ALU_LAT  = ALU_LAT_DEF,
    parameter int MEM_LAT  = MEM_LAT_DEF,
    parameter int LONG_LAT = LONG_LAT_DEF,
    parameter int MAX_LAT  = MAX_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic             alu_src,
    input  logic             alu_reg_write,
    input  logic             mem_reg_write,
    input  logic             long_write,
    input  logic             mem_write,
    input  logic             branch,
    output logic             iss_valid,
    output logic [1:0]       iss_class,
    output logic [REG_W-1:0] iss_dest,
    input  logic             br_resolved,
    input  logic             br_taken,
    output logic             flush,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_reg
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int CNT_W = $clog2(LONG_LAT + 1);

    state_e                state_q, state_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]      long_cnt_q, long_cnt_d;

    iss_class_e            cls;
    logic [REG_W-1:0]      dest;
    logic [LAT_W-1:0]      lat;
    logic                  rt_used;
    logic                  raw, waw, slot_conflict, long_busy;
    logic                  ins_valid;
    logic [MAX_LAT:1]      slot_busy;

    // Destination decode; long > mem > alu.
    always_comb begin
        cls  = CLS_NONE;
        dest = '0;
        lat  = '0;
        if (long_write) begin
            cls  = CLS_LONG;
            dest = rd;
            lat  = LAT_W'(LONG_LAT);
        end else if (mem_reg_write) begin
            cls  = CLS_MEM;
            dest = rt;
            lat  = LAT_W'(MEM_LAT);
        end else if (alu_reg_write) begin
            cls  = CLS_ALU;
            dest = alu_src ? rt : rd;
            lat  = LAT_W'(ALU_LAT);
        end
    end

    // Hazard detection uses registered state only; dec_valid plays no part.
    always_comb begin
        rt_used   = !alu_src || mem_write || branch;
        raw       = (rs != '0 && pending_q[rs]) || (rt_used && rt != '0 && pending_q[rt]);
        waw       = (dest != '0) && pending_q[dest];
        long_busy = (cls == CLS_LONG) && (long_cnt_q != '0);

        // Register 0 is never written back, so it needs no port slot.
        slot_conflict = 1'b0;
        if (dest != '0) begin
            for (int k = 1; k <= MAX_LAT; k++) begin
                if (lat == LAT_W'(k)) begin
                    slot_conflict = slot_busy[k];
                end
            end
        end

        dec_ready = (state_q == ST_RUN) && !raw && !waw && !slot_conflict && !long_busy;
        iss_valid = dec_valid && dec_ready;
        iss_class = iss_valid ? cls  : CLS_NONE;
        iss_dest  = iss_valid ? dest : '0;
        ins_valid = iss_valid && (dest != '0);
        flush     = (state_q == ST_FLUSH);
    end

    // A writeback and an issue never target the same register in one cycle
    // (WAW stalls the issue), so clear-then-set order is irrelevant.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) begin
            pending_d[wb_reg] = 1'b0;
        end
        if (ins_valid) begin
            pending_d[dest] = 1'b1;
        end
    end

    // The issue cycle is the first busy cycle of the long unit, so the
    // counter is loaded with LONG_LAT-1 and the next long op can issue
    // exactly LONG_LAT cycles later.
    always_comb begin
        long_cnt_d = long_cnt_q;
        if (long_cnt_q != '0) begin
            long_cnt_d = long_cnt_q - CNT_W'(1);
        end
        if (iss_valid && cls == CLS_LONG) begin
            long_cnt_d = CNT_W'(LONG_LAT - 1);
        end
    end

    // Branch FSM: hold decode until the branch resolves, then flush one cycle
    // if taken. Outcomes arriving outside BR_WAIT are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (iss_valid && branch) state_d = ST_BR_WAIT;
            ST_BR_WAIT: if (br_resolved)         state_d = br_taken ? ST_FLUSH : ST_RUN;
            ST_FLUSH:                            state_d = ST_RUN;
            default:                             state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pending_q  <= '0;
            long_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            long_cnt_q <= long_cnt_d;
        end
    end

    issue_scoreboard_wb_sched #(
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_wb_sched (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_valid (ins_valid),
        .ins_lat   (lat),
        .ins_reg   (dest),
        .slot_busy (slot_busy),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg)
    );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus random
// instruction streams checked every cycle against a timeline model that
// books writebacks and register-ready times by absolute cycle number.
module tb_issue_scoreboard;

    localparam int ALU_L  = 1;
    localparam int MEM_L  = 3;
    localparam int LONG_L = 6;
    localparam int MAX_L  = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid, dec_ready;
    logic [4:0] rs, rt, rd;
    logic       alu_src, alu_reg_write, mem_reg_write, long_write, mem_write, branch;
    logic       iss_valid;
    logic [1:0] iss_class;
    logic [4:0] iss_dest;
    logic       br_resolved, br_taken;
    logic       flush, wb_valid;
    logic [4:0] wb_reg;

    always #5 clk = ~clk;

    issue_scoreboard #(
        .ALU_LAT (ALU_L), .MEM_LAT (MEM_L), .LONG_LAT (LONG_L), .MAX_LAT (MAX_L)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .dec_valid (dec_valid), .dec_ready (dec_ready),
        .rs (rs), .rt (rt), .rd (rd),
        .alu_src (alu_src), .alu_reg_write (alu_reg_write),
        .mem_reg_write (mem_reg_write), .long_write (long_write),
        .mem_write (mem_write), .branch (branch),
        .iss_valid (iss_valid), .iss_class (iss_class), .iss_dest (iss_dest),
        .br_resolved (br_resolved), .br_taken (br_taken),
        .flush (flush), .wb_valid (wb_valid), .wb_reg (wb_reg)
    );

    typedef struct {
        bit [4:0] rs, rt, rd;
        bit       alu_src, alu_w, mem_w, long_w, st, br;
    } instr_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: absolute-cycle timeline.
    int cyc;
    int ready_cyc [32];     // first cycle a register may be read/written again
    int wb_at [int];        // cycle -> register written back in that cycle
    int long_free;          // first cycle a new long op may issue
    bit m_wait, m_flush;    // waiting on a branch / flushing this cycle

    // Branch-outcome driving for directed tests, or random when rand_br.
    bit rand_br = 0;
    int br_at   = -1;
    bit br_tk   = 0;

    int flush_cnt, flush_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc       = 0;
        foreach (ready_cyc[i]) ready_cyc[i] = 0;
        wb_at.delete();
        long_free = 0;
        m_wait    = 0;
        m_flush   = 0;
        flush_cnt = 0;
        flush_cyc = -1;
    endtask

    function automatic bit busy(input bit [4:0] r);
        return (r != 0) && (ready_cyc[r] > cyc);
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i = '{rs: 0, rt: 0, rd: 0, alu_src: 0, alu_w: 0, mem_w: 0, long_w: 0, st: 0, br: 0};
        return i;
    endfunction

    function automatic instr_t alu_r(input bit [4:0] s, input bit [4:0] t, input bit [4:0] d);
        instr_t i = nop();
        i.rs = s; i.rt = t; i.rd = d; i.alu_w = 1;
        return i;
    endfunction

    function automatic instr_t load(input bit [4:0] s, input bit [4:0] t);
        instr_t i = nop();
        i.rs = s; i.rt = t; i.alu_src = 1; i.mem_w = 1;
        return i;
    endfunction

    function automatic instr_t longop(input bit [4:0] s, input bit [4:0] t, input bit [4:0] d);
        instr_t i = nop();
        i.rs = s; i.rt = t; i.rd = d; i.long_w = 1;
        return i;
    endfunction

    function automatic instr_t br(input bit [4:0] s, input bit [4:0] t);
        instr_t i = nop();
        i.rs = s; i.rt = t; i.br = 1;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        rs = i.rs; rt = i.rt; rd = i.rd;
        alu_src = i.alu_src; alu_reg_write = i.alu_w; mem_reg_write = i.mem_w;
        long_write = i.long_w; mem_write = i.st; branch = i.br;
    endtask

    // One clock cycle, entered and left at a falling edge. Inputs are already
    // driven; outputs are compared against the model, then the model advances.
    task automatic do_cycle(output bit issued);
        int cls, dest, lat;
        bit rt_used, raw, waw, conf, lbusy, exp_ready, exp_iss, nxt_wait, nxt_flush;
        if (rand_br) begin
            br_resolved = ($urandom_range(0, 3) == 0);
            br_taken    = 1'($urandom_range(0, 1));
        end else begin
            br_resolved = (cyc == br_at);
            br_taken    = br_tk;
        end
        #1;
        cls = 0; dest = 0; lat = 0;
        if (long_write)         begin cls = 3; dest = int'(rd); lat = LONG_L; end
        else if (mem_reg_write) begin cls = 2; dest = int'(rt); lat = MEM_L;  end
        else if (alu_reg_write) begin cls = 1; dest = alu_src ? int'(rt) : int'(rd); lat = ALU_L; end
        rt_used   = !alu_src || mem_write || branch;
        raw       = busy(rs) || (rt_used && busy(rt));
        waw       = busy(5'(dest));
        conf      = (dest != 0) && wb_at.exists(cyc + lat);
        lbusy     = (cls == 3) && (cyc < long_free);
        exp_ready = !m_wait && !m_flush && !raw && !waw && !conf && !lbusy;
        exp_iss   = dec_valid && exp_ready;

        check("dec_ready", 32'(dec_ready), 32'(exp_ready));
        check("iss_valid", 32'(iss_valid), 32'(exp_iss));
        check("iss_class", 32'(iss_class), exp_iss ? 32'(cls) : 32'd0);
        check("iss_dest",  32'(iss_dest),  exp_iss ? 32'(dest) : 32'd0);
        check("flush",     32'(flush),     32'(m_flush));
        check("wb_valid",  32'(wb_valid),  32'(wb_at.exists(cyc)));
        check("wb_reg",    32'(wb_reg),    wb_at.exists(cyc) ? 32'(wb_at[cyc]) : 32'd0);

        issued = iss_valid;
        if (flush) begin flush_cnt++; flush_cyc = cyc; end

        if (wb_at.exists(cyc)) wb_at.delete(cyc);
        if (exp_iss) begin
            if (dest != 0) begin
                ready_cyc[dest]   = cyc + lat + 1;
                wb_at[cyc + lat]  = dest;
            end
            if (cls == 3) long_free = cyc + LONG_L;
        end
        nxt_flush = m_wait && br_resolved && br_taken;
        nxt_wait  = m_wait ? !br_resolved : (exp_iss && branch);
        m_flush   = nxt_flush;
        m_wait    = nxt_wait;
        cyc++;
        @(negedge clk);
    endtask

    // Offer one instruction until it issues (bounded); returns the issue cycle or -1.
    task automatic run_instr(input instr_t i, input int budget, output int icyc);
        bit got;
        icyc = -1;
        drive(i);
        dec_valid = 1'b1;
        for (int n = 0; n < budget; n++) begin
            do_cycle(got);
            if (got) begin
                icyc = cyc - 1;
                break;
            end
        end
        dec_valid = 1'b0;
        drive(nop());
    endtask

    task automatic idle(input int n);
        bit got;
        dec_valid = 1'b0;
        drive(nop());
        for (int k = 0; k < n; k++) do_cycle(got);
    endtask

    // Hold reset for n cycles, checking the reset outputs, then release.
    task automatic hold_reset(input int n);
        rst_n       = 1'b0;
        dec_valid   = 1'b0;
        br_resolved = 1'b0;
        br_taken    = 1'b0;
        drive(nop());
        for (int k = 0; k < n; k++) begin
            #1;
            check("rst_wb_valid",  32'(wb_valid),  32'd0);
            check("rst_wb_reg",    32'(wb_reg),    32'd0);
            check("rst_flush",     32'(flush),     32'd0);
            check("rst_dec_ready", 32'(dec_ready), 32'd1);
            @(negedge clk);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int ic;
        instr_t ri;
        int kind;
        rst_n = 1'b0;
        dec_valid = 1'b0;
        br_resolved = 1'b0;
        br_taken = 1'b0;
        drive(nop());
        model_reset();
        @(negedge clk);

        // ALU r3 then dependent reader of r3.
        hold_reset(2);
        run_instr(alu_r(1, 2, 3), 4, ic);
        check("alu_issue_cyc", 32'(ic), 32'd0);
        run_instr(alu_r(3, 0, 4), 8, ic);
        check("alu_dep_issue_cyc", 32'(ic), 32'd2);

        // Load r5 then ALU r7 colliding on the writeback port.
        hold_reset(2);
        run_instr(load(1, 5), 4, ic);
        check("load_issue_cyc", 32'(ic), 32'd0);
        idle(1);
        run_instr(alu_r(1, 2, 7), 8, ic);
        check("slot_conflict_issue_cyc", 32'(ic), 32'd3);
        idle(3);

        // Back-to-back long ops, then a load reading the first result.
        hold_reset(2);
        run_instr(longop(1, 2, 9), 4, ic);
        check("long1_issue_cyc", 32'(ic), 32'd0);
        run_instr(longop(1, 2, 10), 12, ic);
        check("long2_issue_cyc", 32'(ic), 32'd6);
        run_instr(load(9, 11), 12, ic);
        check("long_dep_issue_cyc", 32'(ic), 32'd7);
        idle(8);

        // Taken branch resolved at cycle 4.
        hold_reset(2);
        br_at = 4; br_tk = 1;
        run_instr(br(1, 2), 4, ic);
        check("br_taken_issue_cyc", 32'(ic), 32'd0);
        run_instr(alu_r(1, 2, 8), 12, ic);
        check("after_flush_issue_cyc", 32'(ic), 32'd6);
        check("flush_count", 32'(flush_cnt), 32'd1);
        check("flush_cycle", 32'(flush_cyc), 32'd5);
        idle(2);

        // Not-taken branch resolved at cycle 2.
        hold_reset(2);
        br_at = 2; br_tk = 0;
        run_instr(br(3, 4), 4, ic);
        run_instr(alu_r(1, 2, 8), 12, ic);
        check("br_nt_issue_cyc", 32'(ic), 32'd3);
        check("br_nt_flush_count", 32'(flush_cnt), 32'd0);
        br_at = -1;
        idle(2);

        // Reset with a load to r4 in flight.
        hold_reset(2);
        run_instr(load(1, 4), 4, ic);
        idle(1);
        hold_reset(3);
        run_instr(alu_r(4, 0, 6), 4, ic);
        check("post_reset_issue_cyc", 32'(ic), 32'd0);
        idle(2);

        // Random streams with random branch outcomes and occasional resets.
        hold_reset(2);
        rand_br = 1;
        for (int n = 0; n < 2000; n++) begin
            bit got;
            if (n % 500 == 499) hold_reset(2);
            ri = nop();
            ri.rs = 5'($urandom_range(0, 7));
            ri.rt = 5'($urandom_range(0, 7));
            ri.rd = 5'($urandom_range(0, 7));
            kind  = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2: begin ri.alu_w = 1; ri.alu_src = 1'($urandom_range(0, 1)); end
                3, 4:    begin ri.mem_w = 1; ri.alu_src = 1; end
                5:       begin ri.st = 1; ri.alu_src = 1; end
                6:       ri.long_w = 1;
                7:       ri.br = 1;
                default: ri.alu_src = 1'($urandom_range(0, 1));
            endcase
            drive(ri);
            dec_valid = ($urandom_range(0, 3) != 0);
            do_cycle(got);
        end
        rand_br = 0;
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
